// File: rtl/demux_sched_pkg.sv
// Shared definitions for the round-robin byte demux sequencer: FSM encoding and default sizes.
package demux_sched_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    STALL  = 2'd2
  } state_t;

  localparam int DEF_NUM_LANES = 4;
  localparam int DEF_DATA_W    = 8;
  localparam int DEF_STALL_MAX = 15;

endpackage

// File: rtl/demux_rr_ptr.sv
// Round-robin lane pointer: PTR_W-bit counter that advances on en and wraps naturally
// because the lane count is a power of two.
module demux_rr_ptr #(
  parameter int PTR_W = 2
) (
  input  logic             clk_2f,
  input  logic             reset_L,
  input  logic             en,
  output logic [PTR_W-1:0] ptr
);

  always_ff @(posedge clk_2f or negedge reset_L) begin
    if (!reset_L) begin
      ptr <= '0;
    end else if (en) begin
      ptr <= ptr + 1'b1;
    end
  end

endmodule

// File: rtl/demux_lane_sched.sv
// Sequencer dealing one byte stream to NUM_LANES lanes in strict round-robin, stalling on a full lane.
// Optional per-lane transfer counters are built when LANE_STATS_EN is defined.
module demux_lane_sched
  import demux_sched_pkg::*;
#(
  parameter int NUM_LANES = DEF_NUM_LANES,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int PTR_W     = 2,
  parameter int STALL_MAX = DEF_STALL_MAX,
  parameter int CNT_W     = 8
) (
  input  logic                        clk_2f,
  input  logic                        reset_L,
  input  logic                        valid_in,
  input  logic [DATA_W-1:0]           data_in,
  output logic                        ready_out,
  input  logic [NUM_LANES-1:0]        lane_full,
  output logic [NUM_LANES-1:0]        validout,
  output logic [NUM_LANES*DATA_W-1:0] dataout,
  output logic [PTR_W-1:0]            sel_ptr,
  output logic                        err_stall,
  output logic [NUM_LANES*CNT_W-1:0]  lane_cnt
);

  localparam int SCNT_W = $clog2(STALL_MAX + 1);
  localparam logic [SCNT_W-1:0] SMAX = SCNT_W'(STALL_MAX);
  localparam logic [SCNT_W-1:0] ONE  = SCNT_W'(1);

  state_t            state;
  logic [SCNT_W-1:0] stall_cnt;
  logic              blocked;
  logic              xfer;

  // The target lane is never skipped: a full lane holds the whole stream.
  assign blocked   = lane_full[sel_ptr];
  assign ready_out = ~blocked & ((state != IDLE) | valid_in);
  assign xfer      = valid_in & ready_out;

  demux_rr_ptr #(.PTR_W(PTR_W)) u_rr_ptr (
    .clk_2f  (clk_2f),
    .reset_L (reset_L),
    .en      (xfer),
    .ptr     (sel_ptr)
  );

  always_ff @(posedge clk_2f or negedge reset_L) begin
    if (!reset_L) begin
      validout <= '0;
      dataout  <= '0;
    end else begin
      validout <= '0;
      if (xfer) begin
        validout[sel_ptr]                       <= 1'b1;
        dataout[int'(sel_ptr)*DATA_W +: DATA_W] <= data_in;
      end
    end
  end

  // stall_cnt counts consecutive blocked cycles; err_stall latches once it reaches STALL_MAX.
  always_ff @(posedge clk_2f or negedge reset_L) begin
    if (!reset_L) begin
      state     <= IDLE;
      stall_cnt <= '0;
      err_stall <= 1'b0;
    end else begin
      case (state)
        IDLE, ACTIVE: begin
          if (valid_in && blocked) begin
            state     <= STALL;
            stall_cnt <= ONE;
            if (SMAX <= ONE) err_stall <= 1'b1;
          end else if (valid_in) begin
            state <= ACTIVE;
          end
        end
        STALL: begin
          if (!blocked || !valid_in) begin
            state     <= ACTIVE;
            stall_cnt <= '0;
          end else begin
            if (stall_cnt < SMAX) stall_cnt <= stall_cnt + 1'b1;
            if (stall_cnt >= SMAX - ONE) err_stall <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          stall_cnt <= '0;
        end
      endcase
    end
  end

`ifdef LANE_STATS_EN
  always_ff @(posedge clk_2f or negedge reset_L) begin
    if (!reset_L) begin
      lane_cnt <= '0;
    end else if (xfer) begin
      lane_cnt[int'(sel_ptr)*CNT_W +: CNT_W] <= lane_cnt[int'(sel_ptr)*CNT_W +: CNT_W] + 1'b1;
    end
  end
`else
  assign lane_cnt = '0;
`endif

endmodule
